// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   seq_state_e         : sequencer FSM state encoding
//   MDU_TIMEOUT_DEFAULT : default cycle limit for a multicycle MDU op
//   REG_ZERO            : architectural zero register index
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_REDIR_PEND = 2'd1,
    ST_MDU_WAIT   = 2'd2
  } seq_state_e;

  localparam int MDU_TIMEOUT_DEFAULT = 64;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (purely combinational).
//   mem_read_ex_i : load instruction in EX
//   rt_ex_i       : load destination register
//   rs_id_i       : ID source register rs
//   rt_id_i       : ID source register rt
//   uses_rt_id_i  : ID instruction actually reads rt
//   load_use_o    : ID must stall one cycle behind the load
module load_use_detect
  import mips_pkg::*;
(
  input  logic       mem_read_ex_i,
  input  logic [4:0] rt_ex_i,
  input  logic [4:0] rs_id_i,
  input  logic [4:0] rt_id_i,
  input  logic       uses_rt_id_i,
  output logic       load_use_o
);

  // Writes to r0 are discarded, so a load targeting it never creates a hazard.
  assign load_use_o = mem_read_ex_i && (rt_ex_i != REG_ZERO) &&
                      ((rt_ex_i == rs_id_i) || (uses_rt_id_i && (rt_ex_i == rt_id_i)));

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencing controller: PC/IF-ID/ID-EX write enables, flushes,
// EX/MEM bubble, redirect target latching, MDU wait with timeout, and
// saturating stall/flush performance counters.
//
//   state         | meaning
//   --------------+-----------------------------------------------------
//   ST_RUN        | normal flow; resolves redirect/MDU/load-use/fetch stall
//   ST_REDIR_PEND | redirect accepted, waiting for imem_ready to load PC
//   ST_MDU_WAIT   | multicycle MDU busy; pipeline frozen until done/timeout
//
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   mem_read_ex, rt_ex              : load in EX and its destination
//   rs_id, rt_id, uses_rt_id        : ID source registers
//   redirect_valid, redirect_pc     : branch/jump redirect from EX
//   mdu_start_ex, mdu_done          : MDU handshake
//   imem_ready                      : instruction memory accepts fetch
//   pc_write ... exmem_bubble       : pipeline control outputs
//   pc_target                       : PC to load when pc_load_redirect=1
//   mdu_timeout_err                 : sticky MDU timeout flag
//   stall_cnt, flush_cnt            : saturating performance counters
module pipe_seq_ctrl
  import mips_pkg::*;
#(
  parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read_ex,
  input  logic [4:0]       rt_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rt_id,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  input  logic             mdu_start_ex,
  input  logic             mdu_done,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             pc_load_redirect,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_bubble,
  output logic             mdu_timeout_err,
  output logic [31:0]      pc_target,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TMR_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
  // Down-counter reaches zero on the MDU_TIMEOUT-th waiting cycle.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MDU_TIMEOUT - 1);

  seq_state_e       state_q, state_d;
  logic [31:0]      target_q, target_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic        load_use;
  logic        pc_write_c, pc_load_c, ifid_write_c, ifid_flush_c;
  logic        idex_write_c, idex_flush_c, bubble_c;
  logic [31:0] pc_target_c;

  load_use_detect u_load_use (
    .mem_read_ex_i (mem_read_ex),
    .rt_ex_i       (rt_ex),
    .rs_id_i       (rs_id),
    .rt_id_i       (rt_id),
    .uses_rt_id_i  (uses_rt_id),
    .load_use_o    (load_use)
  );

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    tmr_d        = tmr_q;
    err_d        = err_q;
    pc_write_c   = 1'b1;
    pc_load_c    = 1'b0;
    ifid_write_c = 1'b1;
    ifid_flush_c = 1'b0;
    idex_write_c = 1'b1;
    idex_flush_c = 1'b0;
    bubble_c     = 1'b0;
    pc_target_c  = target_q;

    unique case (state_q)
      ST_RUN: begin
        if (redirect_valid) begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          pc_target_c  = redirect_pc;
          if (imem_ready) begin
            pc_load_c = 1'b1;
          end else begin
            pc_write_c = 1'b0;
            target_d   = redirect_pc;
            state_d    = ST_REDIR_PEND;
          end
        end else if (mdu_start_ex) begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          idex_write_c = 1'b0;
          bubble_c     = 1'b1;
          tmr_d        = TMR_LOAD;
          state_d      = ST_MDU_WAIT;
        end else if (load_use) begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          idex_flush_c = 1'b1;
        end else if (!imem_ready) begin
          pc_write_c   = 1'b0;
          ifid_flush_c = 1'b1;
        end
      end

      ST_REDIR_PEND: begin
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
        if (imem_ready) begin
          pc_load_c = 1'b1;
          state_d   = ST_RUN;
        end else begin
          pc_write_c = 1'b0;
        end
      end

      ST_MDU_WAIT: begin
        if (mdu_done) begin
          state_d = ST_RUN;
        end else begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          idex_write_c = 1'b0;
          bubble_c     = 1'b1;
          if (tmr_q == '0) begin
            err_d   = 1'b1;
            state_d = ST_RUN;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      target_q <= '0;
      tmr_q    <= '0;
      err_q    <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      tmr_q    <= tmr_d;
      err_q    <= err_d;
      if (!pc_write_c && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (idex_flush_c && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  // Combinational outputs are forced low for the whole time reset is held.
  assign pc_write         = rst_n & pc_write_c;
  assign pc_load_redirect = rst_n & pc_load_c;
  assign ifid_write       = rst_n & ifid_write_c;
  assign ifid_flush       = rst_n & ifid_flush_c;
  assign idex_write       = rst_n & idex_write_c;
  assign idex_flush       = rst_n & idex_flush_c;
  assign exmem_bubble     = rst_n & bubble_c;
  assign pc_target        = rst_n ? pc_target_c : 32'd0;
  assign mdu_timeout_err  = err_q;
  assign stall_cnt        = stall_q;
  assign flush_cnt        = flush_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
module tb_pipe_seq_ctrl;

  localparam int CNT_W = 6;

  // {pc_write, pc_load_redirect, ifid_write, ifid_flush, idex_write, idex_flush, exmem_bubble}
  localparam logic [6:0] P_IDLE  = 7'b1010100;
  localparam logic [6:0] P_LU    = 7'b0000110;
  localparam logic [6:0] P_RGO   = 7'b1111110;
  localparam logic [6:0] P_RWAIT = 7'b0011110;
  localparam logic [6:0] P_FSTL  = 7'b0011100;
  localparam logic [6:0] P_HOLD  = 7'b0000001;
  localparam logic [6:0] P_ZERO  = 7'b0000000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mem_read_ex, uses_rt_id, redirect_valid, mdu_start_ex, mdu_done, imem_ready;
  logic [4:0]       rt_ex, rs_id, rt_id;
  logic [31:0]      redirect_pc;
  logic             pc_write, pc_load_redirect, ifid_write, ifid_flush;
  logic             idex_write, idex_flush, exmem_bubble, mdu_timeout_err;
  logic [31:0]      pc_target;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_seq_ctrl #(.MDU_TIMEOUT(64), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_read_ex      (mem_read_ex),
    .rt_ex            (rt_ex),
    .rs_id            (rs_id),
    .rt_id            (rt_id),
    .uses_rt_id       (uses_rt_id),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .mdu_start_ex     (mdu_start_ex),
    .mdu_done         (mdu_done),
    .imem_ready       (imem_ready),
    .pc_write         (pc_write),
    .pc_load_redirect (pc_load_redirect),
    .ifid_write       (ifid_write),
    .ifid_flush       (ifid_flush),
    .idex_write       (idex_write),
    .idex_flush       (idex_flush),
    .exmem_bubble     (exmem_bubble),
    .mdu_timeout_err  (mdu_timeout_err),
    .pc_target        (pc_target),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [6:0] exp);
    chk(tag, {57'd0, pc_write, pc_load_redirect, ifid_write, ifid_flush,
              idex_write, idex_flush, exmem_bubble}, {57'd0, exp});
  endtask

  // Inputs are already applied (posedge+1); check at negedge, advance to next posedge+1.
  task automatic cyc_chk(input string tag, input logic [6:0] exp);
    @(negedge clk);
    chk_out(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    mem_read_ex = 0; rt_ex = 0; rs_id = 0; rt_id = 0; uses_rt_id = 0;
    redirect_valid = 0; redirect_pc = 0; mdu_start_ex = 0; mdu_done = 0;
    imem_ready = 1;
  endtask

  initial begin
    // Reset with hazardous inputs present: outputs must still be all zero.
    rst_n = 0;
    clr_inputs();
    mem_read_ex = 1; rt_ex = 5; rs_id = 5; redirect_valid = 1; redirect_pc = 32'hFFFF_0000;
    repeat (2) @(posedge clk);
    #2;
    chk_out("rst_ctrl", P_ZERO);
    chk("rst_target", pc_target, 0);
    chk("rst_cnts", {stall_cnt, flush_cnt, mdu_timeout_err}, 0);
    clr_inputs();
    @(posedge clk); #1;
    rst_n = 1;

    cyc_chk("first_run_idle", P_IDLE);

    // Load-use on rs
    mem_read_ex = 1; rt_ex = 5; rs_id = 5;
    cyc_chk("lu_rs", P_LU);
    chk("lu_rs_stall_cnt", stall_cnt, 1);
    chk("lu_rs_flush_cnt", flush_cnt, 1);

    // Load to r0 never stalls
    rt_ex = 0; rs_id = 0;
    cyc_chk("lu_r0", P_IDLE);
    chk("lu_r0_stall_cnt", stall_cnt, 1);

    // rt match only counts when ID reads rt
    rt_ex = 7; rs_id = 3; rt_id = 7; uses_rt_id = 0;
    cyc_chk("lu_rt_unused", P_IDLE);
    uses_rt_id = 1;
    cyc_chk("lu_rt_used", P_LU);
    chk("lu_rt_stall_cnt", stall_cnt, 2);
    clr_inputs();

    // Redirect with fetch ready: same-cycle load
    redirect_valid = 1; redirect_pc = 32'h0040_0100;
    @(negedge clk);
    chk_out("redir_now", P_RGO);
    chk("redir_now_target", pc_target, 32'h0040_0100);
    @(posedge clk); #1;

    // Redirect beats load-use and MDU start
    redirect_pc = 32'h0000_0ABC; mem_read_ex = 1; rt_ex = 9; rs_id = 9; mdu_start_ex = 1;
    @(negedge clk);
    chk_out("redir_prio", P_RGO);
    chk("redir_prio_target", pc_target, 32'h0000_0ABC);
    @(posedge clk); #1;
    clr_inputs();
    cyc_chk("redir_prio_no_mdu", P_IDLE);
    chk("redir_prio_cnts", {stall_cnt, flush_cnt}, {6'd2, 6'd4});

    // Redirect with fetch not ready for 3 cycles
    redirect_valid = 1; redirect_pc = 32'h0000_0200; imem_ready = 0;
    cyc_chk("redir_wait_0", P_RWAIT);
    redirect_valid = 0; redirect_pc = 32'hDEAD_BEEF;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      chk_out($sformatf("redir_wait_%0d", i), P_RWAIT);
      chk($sformatf("redir_wait_target_%0d", i), pc_target, 32'h0000_0200);
      @(posedge clk); #1;
    end
    imem_ready = 1;
    @(negedge clk);
    chk_out("redir_go", P_RGO);
    chk("redir_go_target", pc_target, 32'h0000_0200);
    @(posedge clk); #1;
    cyc_chk("redir_done_idle", P_IDLE);
    chk("redir_pend_cnts", {stall_cnt, flush_cnt}, {6'd5, 6'd8});

    // Fetch stall, and load-use taking priority over it
    imem_ready = 0;
    cyc_chk("fetch_stall", P_FSTL);
    mem_read_ex = 1; rt_ex = 4; rs_id = 4;
    cyc_chk("lu_over_fetch", P_LU);
    clr_inputs();
    chk("fetch_cnts", {stall_cnt, flush_cnt}, {6'd7, 6'd9});

    // MDU op finishing after 10 hold cycles; redirect/start ignored while busy
    mdu_start_ex = 1;
    cyc_chk("mdu_start", P_HOLD);
    mdu_start_ex = 0;
    for (int i = 1; i < 10; i++) begin
      redirect_valid = (i == 3);
      redirect_pc    = 32'h0000_1234;
      mdu_start_ex   = (i == 5);
      cyc_chk($sformatf("mdu_hold_%0d", i), P_HOLD);
    end
    clr_inputs();
    mdu_done = 1;
    cyc_chk("mdu_release", P_IDLE);
    mdu_done = 0;
    cyc_chk("mdu_after_run", P_IDLE);
    chk("mdu_stall_cnt", stall_cnt, 17);
    chk("mdu_no_err", mdu_timeout_err, 0);

    // MDU timeout after 64 waiting cycles; stall counter saturates on the way
    mdu_start_ex = 1;
    cyc_chk("to_start", P_HOLD);
    mdu_start_ex = 0;
    for (int i = 1; i <= 64; i++) begin
      cyc_chk($sformatf("to_hold_%0d", i), P_HOLD);
      if (i == 45) chk("stall_reach_max", stall_cnt, 63);
      if (i == 63) chk("to_err_not_yet", mdu_timeout_err, 0);
    end
    chk("to_err_set", mdu_timeout_err, 1);
    chk("stall_saturated", stall_cnt, 63);
    cyc_chk("to_back_in_run", P_IDLE);
    imem_ready = 0;
    cyc_chk("sat_fetch_stall", P_FSTL);
    imem_ready = 1;
    chk("stall_stays_max", stall_cnt, 63);
    chk("err_sticky", mdu_timeout_err, 1);

    // Reset pulsed in the middle of an MDU wait
    mdu_start_ex = 1;
    cyc_chk("rst_mdu_start", P_HOLD);
    mdu_start_ex = 0;
    cyc_chk("rst_mdu_hold", P_HOLD);
    rst_n = 0;
    #2;
    chk_out("rst_mid_mdu", P_ZERO);
    chk("rst_mid_mdu_regs", {stall_cnt, flush_cnt, mdu_timeout_err}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    cyc_chk("rst_mdu_run", P_IDLE);

    // Reset pulsed during a pending redirect: nothing survives
    redirect_valid = 1; redirect_pc = 32'h0000_0300; imem_ready = 0;
    cyc_chk("rst_rp_enter", P_RWAIT);
    redirect_valid = 0;
    rst_n = 0;
    #2;
    chk_out("rst_mid_redir", P_ZERO);
    @(posedge clk); #1;
    rst_n = 1;
    imem_ready = 1;
    @(negedge clk);
    chk_out("rst_rp_run", P_IDLE);
    chk("rst_rp_target", pc_target, 0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
